// File: rtl/ysyx_23060077_lsu_if.sv
// Core data bus between the LSU (master) and the data memory / interconnect (slave).
// One request channel with a valid/ready handshake, and one response channel that
// carries a single-cycle valid with no backpressure.
interface ysyx_23060077_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [3:0]            mem_req_wstrb;
    logic [1:0]            mem_req_size;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_rdata;
    logic                  mem_rsp_err;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
               mem_req_wstrb, mem_req_size,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
               mem_req_wstrb, mem_req_size,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );
endinterface

// File: rtl/ysyx_23060077_lsu.sv
// ysyx_23060077_lsu: load/store unit behind the EX-stage ALU.
// Runs one data-bus access per accepted request and returns exactly one
// write-back pulse per request, in order, with a single request outstanding.
//
// Build option YSYX_23060077_LSU_MISALIGN_CHECK_EN:
//   defined   -> misaligned half/word requests fault without touching the bus
//   undefined -> misaligned addresses are rounded down to natural alignment
//
// state | meaning
// IDLE  | ex_ready high, waiting for ex_valid
// REQ   | bus request presented, waiting for mem_req_ready
// RSP   | request taken by the bus, waiting for mem_rsp_valid
// DONE  | wb_valid pulse for one cycle
module ysyx_23060077_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    input  logic [3:0]            ex_lsu_opt,
    ysyx_23060077_lsu_if.master   mem,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_rdata,
    output logic                  wb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    logic                  uns_q;
    logic                  fault;
    logic [ADDR_WIDTH-1:0] addr_nat;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [3:0]            st_strb;
    logic [DATA_WIDTH-1:0] rsp_shift;
    logic [DATA_WIDTH-1:0] ld_data;

    wire illegal_size = (ex_lsu_opt[1:0] == 2'b11);

`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
    logic misaligned;

    // Misaligned half/word requests are reported as faults.
    always_comb begin
        misaligned = 1'b0;
        case (ex_lsu_opt[1:0])
            2'b01:   misaligned = ex_addr[0];
            2'b10:   misaligned = (ex_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        fault    = illegal_size | misaligned;
        addr_nat = ex_addr;
    end
`else
    // Misaligned half/word requests are silently rounded down to natural alignment.
    always_comb begin
        fault    = illegal_size;
        addr_nat = ex_addr;
        case (ex_lsu_opt[1:0])
            2'b01:   addr_nat[0]   = 1'b0;
            2'b10:   addr_nat[1:0] = 2'b00;
            default: addr_nat      = ex_addr;
        endcase
    end
`endif

    // Store lane replication and byte strobe; loads never drive a strobe.
    always_comb begin
        st_wdata = ex_wdata;
        st_strb  = 4'b0000;
        case (ex_lsu_opt[1:0])
            2'b00: begin
                st_wdata = {4{ex_wdata[7:0]}};
                st_strb  = 4'b0001 << addr_nat[1:0];
            end
            2'b01: begin
                st_wdata = {2{ex_wdata[15:0]}};
                st_strb  = 4'b0011 << addr_nat[1:0];
            end
            2'b10: begin
                st_wdata = ex_wdata;
                st_strb  = 4'b1111;
            end
            default: begin
                st_wdata = ex_wdata;
                st_strb  = 4'b0000;
            end
        endcase
        if (!ex_lsu_opt[3]) begin
            st_strb = 4'b0000;
        end
    end

    // Load lane extraction and extension, driven by the latched request fields.
    always_comb begin
        rsp_shift = mem.mem_rsp_rdata >> {mem.mem_req_addr[1:0], 3'b000};
        case (mem.mem_req_size)
            2'b00:   ld_data = uns_q ? {24'h0, rsp_shift[7:0]}
                                     : {{24{rsp_shift[7]}}, rsp_shift[7:0]};
            2'b01:   ld_data = uns_q ? {16'h0, rsp_shift[15:0]}
                                     : {{16{rsp_shift[15]}}, rsp_shift[15:0]};
            default: ld_data = rsp_shift;
        endcase
    end

    // Access sequencer with registered bus and write-back outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ex_ready          <= 1'b1;
            uns_q             <= 1'b0;
            mem.mem_req_valid <= 1'b0;
            mem.mem_req_addr  <= '0;
            mem.mem_req_wen   <= 1'b0;
            mem.mem_req_wdata <= '0;
            mem.mem_req_wstrb <= 4'b0000;
            mem.mem_req_size  <= 2'b00;
            wb_valid          <= 1'b0;
            wb_rdata          <= '0;
            wb_err            <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        ex_ready          <= 1'b0;
                        uns_q             <= ex_lsu_opt[2];
                        mem.mem_req_addr  <= addr_nat;
                        mem.mem_req_wen   <= ex_lsu_opt[3];
                        mem.mem_req_wdata <= st_wdata;
                        mem.mem_req_wstrb <= st_strb;
                        mem.mem_req_size  <= ex_lsu_opt[1:0];
                        if (fault) begin
                            state    <= DONE;
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b1;
                            wb_rdata <= '0;
                        end else begin
                            state             <= REQ;
                            mem.mem_req_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_req_ready) begin
                        mem.mem_req_valid <= 1'b0;
                        state             <= RSP;
                    end
                end
                RSP: begin
                    if (mem.mem_rsp_valid) begin
                        state    <= DONE;
                        wb_valid <= 1'b1;
                        wb_err   <= mem.mem_rsp_err;
                        wb_rdata <= (mem.mem_rsp_err || mem.mem_req_wen) ? '0 : ld_data;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_lsu.sv
// Testbench for ysyx_23060077_lsu: directed cases plus randomized requests,
// checked through request/write-back scoreboards against a reference model.
module tb_ysyx_23060077_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_lsu_opt;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic        wb_err;

    ysyx_23060077_lsu_if bus ();

    ysyx_23060077_lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_lsu_opt (ex_lsu_opt),
        .mem        (bus),
        .wb_valid   (wb_valid),
        .wb_rdata   (wb_rdata),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  size;
        int          rdly;
        int          sdly;
        logic [31:0] rdata;
        logic        err;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          c0;
    } wb_t;

    req_t reqq[$];
    wb_t  wbq[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference model: byte counts, remainders and integer sign handling.
    function automatic void ref_model(
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [3:0]  opt,
        input  logic [31:0] rd,
        input  logic        er,
        output bit          flt,
        output logic [31:0] ea,
        output logic [31:0] ew,
        output logic [3:0]  es,
        output logic [31:0] ed,
        output logic        ee
    );
        int unsigned nb;
        int unsigned rem;
        int          off;
        longint      m;
        longint      v;
        logic [63:0] raw;
        case (opt[1:0])
            2'd0:    nb = 1;
            2'd1:    nb = 2;
            2'd2:    nb = 4;
            default: nb = 0;
        endcase
        flt = (nb == 0);
        ea  = a;
        rem = (nb == 0) ? 0 : (a % nb);
        if (rem != 0) begin
`ifdef YSYX_23060077_LSU_MISALIGN_CHECK_EN
            flt = 1'b1;
`else
            ea = a - rem;
`endif
        end
        off = int'(ea % 4);
        es  = (opt[3] && !flt) ? 4'(((1 << nb) - 1) << off) : 4'b0000;
        case (nb)
            1:       ew = (wd & 32'h0000_00ff) * 32'h0101_0101;
            2:       ew = (wd & 32'h0000_ffff) * 32'h0001_0001;
            default: ew = wd;
        endcase
        m   = (longint'(1) << (8 * nb)) - 1;
        raw = {32'h0, rd};
        v   = longint'(raw >> (8 * off)) & m;
        if (!opt[2] && nb < 4 && v >= (m + 1) / 2) v = v - (m + 1);
        ed = v[31:0];
        ee = flt | er;
        if (flt || opt[3] || er) ed = 32'h0;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] opt,
                         input int rdly, input int sdly, input logic [31:0] rd, input logic er,
                         input bit expect_wb);
        bit          flt;
        logic [31:0] ea, ew, ed;
        logic [3:0]  es;
        logic        ee;
        req_t        r;
        wb_t         w;
        int          n;
        n = 0;
        @(negedge clk);
        while (ex_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ex_ready_wait", {31'h0, ex_ready}, 32'h1);
        if (ex_ready !== 1'b1) return;
        ref_model(a, wd, opt, rd, er, flt, ea, ew, es, ed, ee);
        if (!flt) begin
            r.addr = ea; r.wen = opt[3]; r.wdata = ew; r.wstrb = es; r.size = opt[1:0];
            r.rdly = rdly; r.sdly = sdly; r.rdata = rd; r.err = er;
            reqq.push_back(r);
        end
        if (expect_wb) begin
            w.rdata = ed; w.err = ee; w.c0 = cyc;
            w.lat   = flt ? 1 : 3 + rdly + sdly;
            wbq.push_back(w);
        end
        ex_valid   = 1'b1;
        ex_addr    = a;
        ex_wdata   = wd;
        ex_lsu_opt = opt;
        @(negedge clk);
        ex_valid   = 1'b0;
        ex_addr    = $urandom;
        ex_wdata   = $urandom;
        ex_lsu_opt = 4'($urandom_range(0, 15));
    endtask

    // Bus slave: checks each request against the plan and answers with its timing.
    initial begin
        req_t        r;
        logic [31:0] snap_addr;
        logic [3:0]  snap_strb;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;
        bus.mem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.mem_req_valid === 1'b1) begin
                if (reqq.size() == 0) begin
                    check("unexpected_req_addr", bus.mem_req_addr, 32'hxxxx_xxxx);
                    r = '{addr: 32'h0, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0, size: 2'b0,
                          rdly: 0, sdly: 0, rdata: 32'h0, err: 1'b0};
                end else begin
                    r = reqq.pop_front();
                    check("req_addr", bus.mem_req_addr, r.addr);
                    check("req_wen", {31'h0, bus.mem_req_wen}, {31'h0, r.wen});
                    check("req_wstrb", {28'h0, bus.mem_req_wstrb}, {28'h0, r.wstrb});
                    check("req_size", {30'h0, bus.mem_req_size}, {30'h0, r.size});
                    if (r.wen) check("req_wdata", bus.mem_req_wdata, r.wdata);
                end
                snap_addr = bus.mem_req_addr;
                snap_strb = bus.mem_req_wstrb;
                for (int i = 0; i < r.rdly; i++) begin
                    bus.mem_rsp_valid = ($urandom_range(0, 2) == 0);
                    bus.mem_rsp_rdata = $urandom;
                    bus.mem_rsp_err   = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    bus.mem_rsp_valid = 1'b0;
                    bus.mem_rsp_err   = 1'b0;
                    check("req_stable_valid", {31'h0, bus.mem_req_valid}, 32'h1);
                    check("req_stable_addr", bus.mem_req_addr, snap_addr);
                    check("req_stable_wstrb", {28'h0, bus.mem_req_wstrb}, {28'h0, snap_strb});
                end
                bus.mem_req_ready = 1'b1;
                @(negedge clk);
                bus.mem_req_ready = 1'b0;
                repeat (r.sdly) @(negedge clk);
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_rdata = r.rdata;
                bus.mem_rsp_err   = r.err;
                @(negedge clk);
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_err   = 1'b0;
                bus.mem_rsp_rdata = $urandom;
            end
        end
    end

    // Write-back monitor: every pulse must match the oldest outstanding expectation.
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && wb_valid === 1'b1) begin
                if (wbq.size() == 0) begin
                    check("unexpected_wb_valid", {31'h0, wb_valid}, 32'h0);
                end else begin
                    w = wbq.pop_front();
                    check("wb_rdata", wb_rdata, w.rdata);
                    check("wb_err", {31'h0, wb_err}, {31'h0, w.err});
                    check("wb_latency", cyc - w.c0, w.lat);
                    check("ex_ready_busy", {31'h0, ex_ready}, 32'h0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        int          n;
        logic [3:0]  op;
        logic [31:0] a;
        rst_n      = 1'b0;
        ex_valid   = 1'b0;
        ex_addr    = 32'h0;
        ex_wdata   = 32'h0;
        ex_lsu_opt = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_ex_ready", {31'h0, ex_ready}, 32'h1);
        check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check("rst_wb_rdata", wb_rdata, 32'h0);
        check("rst_wb_err", {31'h0, wb_err}, 32'h0);
        check("rst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        check("rst_req_addr", bus.mem_req_addr, 32'h0);
        check("rst_req_wstrb", {28'h0, bus.mem_req_wstrb}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ex_ready", {31'h0, ex_ready}, 32'h1);

        // store byte, signed/unsigned half, stalled word, misaligned word, bus error, illegal size
        issue(32'h8000_0003, 32'h1234_56AB, 4'b1000, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(32'h8000_0002, 32'h0, 4'b0001, 0, 0, 32'h8001_7FFF, 1'b0, 1'b1);
        issue(32'h8000_0002, 32'h0, 4'b0101, 0, 0, 32'h8001_7FFF, 1'b0, 1'b1);
        issue(32'h8000_0010, 32'h0, 4'b0010, 4, 0, 32'hCAFE_F00D, 1'b0, 1'b1);
        issue(32'h8000_0002, 32'h0, 4'b0010, 0, 0, 32'h1122_3344, 1'b0, 1'b1);
        issue(32'h8000_0001, 32'h0, 4'b0000, 1, 2, 32'hFFFF_FFFF, 1'b1, 1'b1);
        issue(32'h8000_0000, 32'h5555_AAAA, 4'b1011, 0, 0, 32'h0, 1'b0, 1'b1);
        issue(32'h8000_0004, 32'h0, 4'b0111, 0, 0, 32'h0, 1'b0, 1'b1);
        issue(32'h8000_0006, 32'hA5A5_1234, 4'b1001, 2, 1, 32'h0, 1'b0, 1'b1);

        for (int k = 0; k < 150; k++) begin
            op[3]   = 1'($urandom_range(0, 1));
            op[2]   = 1'($urandom_range(0, 1));
            op[1:0] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a       = 32'h8000_0000 | ($urandom & 32'h0000_0fff);
            issue(a, $urandom, op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                  ($urandom_range(0, 7) == 0), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // reset while waiting for the response; the late response must be ignored
        issue(32'h8000_0100, 32'h0, 4'b0010, 0, 4, 32'h1357_9BDF, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ex_ready", {31'h0, ex_ready}, 32'h1);
        check("midrst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
        check("midrst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check("midrst_req_addr", bus.mem_req_addr, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) pulses++;
        end
        check("late_rsp_wb_pulses", pulses, 0);
        check("late_rsp_ex_ready", {31'h0, ex_ready}, 32'h1);
        issue(32'h8000_0200, 32'h0, 4'b0000, 0, 0, 32'h0000_0080, 1'b0, 1'b1);

        n = 0;
        while ((wbq.size() != 0 || reqq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("drain_wbq", wbq.size(), 0);
        check("drain_reqq", reqq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
